poly_mul_scheduler: RTL

Sequencer for the ternary-by-mod-q polynomial product e = r·h mod (x^N − 1), used in NTRU-HRSS decryption. It steps a single conditional add/subtract cell over every nonzero coefficient of the ternary operand r. Operands and the accumulator are held in external synchronous RAMs. Zero coefficients of r are skipped, and the block reports completion with a one-cycle `done` pulse.

---
 rtl/ntru_decrypt_pkg.sv | 19 +
 rtl/poly_mul_scheduler_if.sv | 34 +++
 rtl/ternary_mac_cell.sv | 22 ++
 rtl/poly_mul_scheduler.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ntru_decrypt_pkg.sv
// Shared types and default sizing for the NTRU-HRSS decryption datapath.
// The scheduler state encoding lives here so sub-blocks and benches agree on it.
package ntru_decrypt_pkg;

  localparam int N_DEFAULT                = 701;
  localparam int NUM_WIDTH_LENGTH_DEFAULT = 13;
  localparam int ADDR_WIDTH_DEFAULT       = 10;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH_R,
    CHECK_R,
    ROW,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/poly_mul_scheduler_if.sv
// Control handshake plus the r, h and accumulator RAM ports of the product scheduler.
// The master side is the scheduler; the slave side is the RAMs and the requester.
interface poly_mul_scheduler_if
  import ntru_decrypt_pkg::*;
#(
  parameter int ADDR_WIDTH       = ADDR_WIDTH_DEFAULT,
  parameter int NUM_WIDTH_LENGTH = NUM_WIDTH_LENGTH_DEFAULT
);

  logic                        start;
  logic                        busy;
  logic                        done;
  logic [ADDR_WIDTH-1:0]       r_addr;
  logic                        r_nz;
  logic                        r_neg;
  logic [ADDR_WIDTH-1:0]       h_addr;
  logic [NUM_WIDTH_LENGTH-1:0] h_data;
  logic [ADDR_WIDTH-1:0]       e_rd_addr;
  logic [NUM_WIDTH_LENGTH-1:0] e_rd_data;
  logic                        e_wr_en;
  logic [ADDR_WIDTH-1:0]       e_wr_addr;
  logic [NUM_WIDTH_LENGTH-1:0] e_wr_data;

  modport master (
    input  start, r_nz, r_neg, h_data, e_rd_data,
    output busy, done, r_addr, h_addr, e_rd_addr, e_wr_en, e_wr_addr, e_wr_data
  );

  modport slave (
    output start, r_nz, r_neg, h_data, e_rd_data,
    input  busy, done, r_addr, h_addr, e_rd_addr, e_wr_en, e_wr_addr, e_wr_data
  );

endinterface

// File: rtl/ternary_mac_cell.sv
// Combinational e + h or e - h: the sign inverts h bitwise and injects a carry-in,
// giving two's-complement negation without a separate subtractor.
module ternary_mac_cell
  import ntru_decrypt_pkg::*;
#(
  parameter int W = NUM_WIDTH_LENGTH_DEFAULT
) (
  input  logic [W-1:0] e_in,
  input  logic [W-1:0] h_in,
  input  logic         neg,
  output logic [W-1:0] sum
);

  logic [W-1:0] h_x;

  for (genvar gi = 0; gi < W; gi++) begin : g_flip
    assign h_x[gi] = h_in[gi] ^ neg;
  end

  assign sum = e_in + h_x + {{(W-1){1'b0}}, neg};

endmodule

// File: rtl/poly_mul_scheduler.sv
// Sequences e = r*h mod (x^N - 1) over external RAMs, one MAC per cycle,
// skipping zero coefficients of the ternary operand r.
module poly_mul_scheduler
  import ntru_decrypt_pkg::*;
#(
  parameter int N                = N_DEFAULT,
  parameter int NUM_WIDTH_LENGTH = NUM_WIDTH_LENGTH_DEFAULT,
  parameter int ADDR_WIDTH       = ADDR_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  poly_mul_scheduler_if.master  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH:0]   N_EXT    = (ADDR_WIDTH + 1)'(N);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

  state_e                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       i_q, i_d;
  logic [ADDR_WIDTH-1:0]       j_q, j_d;
  logic [ADDR_WIDTH-1:0]       clr_q, clr_d;
  logic [ADDR_WIDTH-1:0]       r_addr_q, r_addr_d;
  logic [ADDR_WIDTH-1:0]       h_addr_q, h_addr_d;
  logic [ADDR_WIDTH-1:0]       e_rd_addr_q, e_rd_addr_d;
  logic [ADDR_WIDTH-1:0]       e_wr_addr_q, e_wr_addr_d;
  logic                        e_wr_en_q, e_wr_en_d;
  logic                        wb_mac_q, wb_mac_d;
  logic                        sign_q, sign_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic [ADDR_WIDTH:0]         idx_inc;
  logic [ADDR_WIDTH-1:0]       idx_next;
  logic [NUM_WIDTH_LENGTH-1:0] mac_sum;

  // (i + j) mod N tracked incrementally: the read address itself is the modular index.
  assign idx_inc  = {1'b0, e_rd_addr_q} + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign idx_next = (idx_inc >= N_EXT) ? ADDR_WIDTH'(idx_inc - N_EXT) : idx_inc[ADDR_WIDTH-1:0];

  ternary_mac_cell #(.W(NUM_WIDTH_LENGTH)) u_mac (
    .e_in (bus.e_rd_data),
    .h_in (bus.h_data),
    .neg  (sign_q),
    .sum  (mac_sum)
  );

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    clr_d       = clr_q;
    r_addr_d    = r_addr_q;
    h_addr_d    = h_addr_q;
    e_rd_addr_d = e_rd_addr_q;
    e_wr_addr_d = e_wr_addr_q;
    e_wr_en_d   = e_wr_en_q;
    wb_mac_d    = wb_mac_q;
    sign_d      = sign_q;
    busy_d      = busy_q;
    done_d      = done_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = CLEAR;
          busy_d      = 1'b1;
          i_d         = '0;
          j_d         = '0;
          clr_d       = '0;
          e_wr_en_d   = 1'b1;
          e_wr_addr_d = '0;
          wb_mac_d    = 1'b0;
        end
      end
      CLEAR: begin
        if (clr_q == LAST_IDX) begin
          state_d   = FETCH_R;
          e_wr_en_d = 1'b0;
          r_addr_d  = i_q;
        end else begin
          clr_d       = clr_q + ONE;
          e_wr_addr_d = clr_q + ONE;
        end
      end
      FETCH_R: begin
        state_d = CHECK_R;
      end
      CHECK_R: begin
        if (bus.r_nz) begin
          state_d     = ROW;
          sign_d      = bus.r_neg;
          j_d         = '0;
          h_addr_d    = '0;
          e_rd_addr_d = i_q;
        end else if (i_q == LAST_IDX) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d  = FETCH_R;
          i_d      = i_q + ONE;
          r_addr_d = i_q + ONE;
        end
      end
      ROW: begin
        // The read issued this cycle becomes next cycle's writeback.
        e_wr_en_d   = 1'b1;
        wb_mac_d    = 1'b1;
        e_wr_addr_d = e_rd_addr_q;
        if (j_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          j_d         = j_q + ONE;
          h_addr_d    = j_q + ONE;
          e_rd_addr_d = idx_next;
        end
      end
      DRAIN: begin
        e_wr_en_d = 1'b0;
        wb_mac_d  = 1'b0;
        if (i_q == LAST_IDX) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d  = FETCH_R;
          i_d      = i_q + ONE;
          r_addr_d = i_q + ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      clr_q       <= '0;
      r_addr_q    <= '0;
      h_addr_q    <= '0;
      e_rd_addr_q <= '0;
      e_wr_addr_q <= '0;
      e_wr_en_q   <= 1'b0;
      wb_mac_q    <= 1'b0;
      sign_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      clr_q       <= clr_d;
      r_addr_q    <= r_addr_d;
      h_addr_q    <= h_addr_d;
      e_rd_addr_q <= e_rd_addr_d;
      e_wr_addr_q <= e_wr_addr_d;
      e_wr_en_q   <= e_wr_en_d;
      wb_mac_q    <= wb_mac_d;
      sign_q      <= sign_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Clear writes and idle cycles force zero so stale RAM read data never leaks out.
  assign bus.e_wr_data = wb_mac_q ? mac_sum : '0;
  assign bus.e_wr_en   = e_wr_en_q;
  assign bus.e_wr_addr = e_wr_addr_q;
  assign bus.e_rd_addr = e_rd_addr_q;
  assign bus.h_addr    = h_addr_q;
  assign bus.r_addr    = r_addr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
